// File: rtl/mbox_rx_buf.sv
// rtl/mbox_rx_buf.sv - mailbox receive buffer: staging word, word FIFO with last flags,
// packet counting, interrupts and the receiver half of the abort handshake.
module mbox_rx_buf #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          aclk,
  input  logic          reset,
  input  logic [31:0]   in_dat,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_done,
  input  logic          in_abort,
  output logic          abort_out,
  input  logic          sw_abort,
  output logic [31:0]   rd_dat,
  output logic          rd_last,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [CW-1:0] pkt_count,
  output logic [CW-1:0] word_count,
  output logic          irq_available,
  output logic          irq_abort_init,
  output logic          irq_abort_done,
  output logic          irq_error
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {NORMAL, REMOTE_ABORT, LOCAL_ABORT, ABORT_CLR} state_t;

  state_t           state, state_n;
  logic [31:0]      mem_dat [DEPTH];
  logic [DEPTH-1:0] mem_last;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [31:0]      stage_dat;
  logic             stage_v, stage_last, pending_last;

  logic is_normal, flush, init_ev, done_ev;
  logic empty, full, accept, pop, push, done_act, err, stage_is_last, head_last;

  always_comb begin
    state_n   = state;
    flush     = 1'b0;
    init_ev   = 1'b0;
    done_ev   = 1'b0;
    abort_out = 1'b0;
    case (state)
      NORMAL: begin
        // Remote abort has priority over a coincident local request.
        if (in_abort) begin
          state_n = REMOTE_ABORT;
          flush   = 1'b1;
          init_ev = 1'b1;
        end else if (sw_abort) begin
          state_n = LOCAL_ABORT;
          flush   = 1'b1;
        end
      end
      REMOTE_ABORT: begin
        abort_out = in_abort;
        if (!in_abort) state_n = NORMAL;
      end
      LOCAL_ABORT: begin
        abort_out = !in_abort;
        if (in_abort) begin
          state_n = ABORT_CLR;
          done_ev = 1'b1;
        end
      end
      ABORT_CLR: begin
        if (!in_abort) state_n = NORMAL;
      end
      default: state_n = NORMAL;
    endcase
  end

  assign is_normal = (state == NORMAL);
  assign empty     = (word_count == '0);
  assign full      = (word_count == CW'(DEPTH));
  assign head_last = mem_last[rd_ptr];

  assign in_ready = !reset && is_normal && !pending_last && (!stage_v || !full);
  assign accept   = in_valid && in_ready;
  assign rd_valid = is_normal && !empty;
  assign pop      = rd_valid && rd_ready;
  assign rd_dat   = empty ? 32'h0 : mem_dat[rd_ptr];
  assign rd_last  = !empty && head_last;

  // A done without a beat closes the staged word, unless that word is already closed.
  assign done_act      = in_done && is_normal && !flush;
  assign err           = done_act && (pending_last || (!accept && (!stage_v || stage_last)));
  assign stage_is_last = stage_v && (stage_last || (done_act && !accept && !err));
  assign push          = is_normal && !flush && stage_v && (accept || stage_is_last) && !full;

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_dat[wr_ptr]  <= stage_dat;
      mem_last[wr_ptr] <= stage_is_last;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state          <= NORMAL;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      word_count     <= '0;
      pkt_count      <= '0;
      stage_dat      <= '0;
      stage_v        <= 1'b0;
      stage_last     <= 1'b0;
      pending_last   <= 1'b0;
      irq_available  <= 1'b0;
      irq_error      <= 1'b0;
      irq_abort_init <= 1'b0;
      irq_abort_done <= 1'b0;
    end else begin
      state          <= state_n;
      irq_available  <= push && stage_is_last;
      irq_error      <= err;
      irq_abort_init <= init_ev;
      irq_abort_done <= done_ev;
      if (flush) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        word_count   <= '0;
        pkt_count    <= '0;
        stage_v      <= 1'b0;
        stage_last   <= 1'b0;
        pending_last <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        word_count <= word_count + CW'(push) - CW'(pop);
        pkt_count  <= pkt_count + CW'(push && stage_is_last) - CW'(pop && head_last);
        if (accept) begin
          stage_dat  <= in_dat;
          stage_v    <= 1'b1;
          stage_last <= in_done;
        end else if (push) begin
          stage_v    <= 1'b0;
          stage_last <= 1'b0;
        end else if (stage_is_last) begin
          stage_last <= 1'b1;
        end
        // Closed word stuck behind a full FIFO: hold it until room appears.
        pending_last <= stage_is_last && !push;
      end
    end
  end

endmodule

// File: tb/tb_mbox_rx_buf.sv
// tb/tb_mbox_rx_buf.sv - directed and random checks of mbox_rx_buf against a queue model.
module tb_mbox_rx_buf;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          aclk = 1'b0;
  logic          reset, in_valid, in_done, in_abort, sw_abort, rd_ready;
  logic [31:0]   in_dat;
  logic          in_ready, abort_out, rd_last, rd_valid;
  logic [31:0]   rd_dat;
  logic [CW-1:0] pkt_count, word_count;
  logic          irq_available, irq_abort_init, irq_abort_done, irq_error;

  mbox_rx_buf #(.DEPTH(DEPTH)) dut (
    .aclk(aclk), .reset(reset), .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
    .in_done(in_done), .in_abort(in_abort), .abort_out(abort_out), .sw_abort(sw_abort),
    .rd_dat(rd_dat), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .pkt_count(pkt_count), .word_count(word_count), .irq_available(irq_available),
    .irq_abort_init(irq_abort_init), .irq_abort_done(irq_abort_done), .irq_error(irq_error)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: FIFO as queues, one staged word, mode 0..3 = normal/remote/local/clear.
  logic [31:0] q_dat[$];
  bit          q_last[$];
  logic [31:0] s_dat;
  bit          s_v, s_last, pend;
  int          mst;
  bit          e_avail, e_err, e_init, e_done;
  int          n_avail, n_err, n_init, n_done;
  logic [31:0] pop_log[$];
  bit          pop_last_log[$];

  function automatic int model_pkts();
    int c = 0;
    foreach (q_last[i]) if (q_last[i]) c++;
    return c;
  endfunction

  task automatic model_flush();
    q_dat.delete();
    q_last.delete();
    s_v = 0; s_last = 0; pend = 0;
  endtask

  task automatic cycle();
    bit rdy_e, rv_e, full, acc, pop, pushed, plast, err, close_now;
    bit na, ne, ni, nd;
    #1;
    if (reset) begin
      model_flush();
      mst = 0; e_avail = 0; e_err = 0; e_init = 0; e_done = 0;
    end
    rdy_e = !reset && mst == 0 && !pend && (!s_v || q_dat.size() < DEPTH);
    rv_e  = mst == 0 && q_dat.size() > 0;
    check_eq("in_ready", 32'(in_ready), 32'(rdy_e));
    check_eq("rd_valid", 32'(rd_valid), 32'(rv_e));
    check_eq("rd_dat", rd_dat, q_dat.size() > 0 ? q_dat[0] : 32'h0);
    check_eq("rd_last", 32'(rd_last), 32'(q_last.size() > 0 ? q_last[0] : 1'b0));
    check_eq("word_count", 32'(word_count), 32'(q_dat.size()));
    check_eq("pkt_count", 32'(pkt_count), 32'(model_pkts()));
    check_eq("abort_out", 32'(abort_out), 32'((mst == 1 && in_abort) || (mst == 2 && !in_abort)));
    check_eq("irq_available", 32'(irq_available), 32'(e_avail));
    check_eq("irq_error", 32'(irq_error), 32'(e_err));
    check_eq("irq_abort_init", 32'(irq_abort_init), 32'(e_init));
    check_eq("irq_abort_done", 32'(irq_abort_done), 32'(e_done));
    if (irq_available) n_avail++;
    if (irq_error) n_err++;
    if (irq_abort_init) n_init++;
    if (irq_abort_done) n_done++;
    if (rd_valid && rd_ready) begin
      pop_log.push_back(rd_dat);
      pop_last_log.push_back(rd_last);
    end
    na = 0; ne = 0; ni = 0; nd = 0;
    if (!reset) begin
      case (mst)
        0: begin
          if (in_abort) begin
            model_flush(); mst = 1; ni = 1;
          end else if (sw_abort) begin
            model_flush(); mst = 2;
          end else begin
            full = q_dat.size() == DEPTH;
            acc = in_valid && rdy_e;
            pop = rv_e && rd_ready;
            err = 0; pushed = 0; plast = 0;
            close_now = s_last;
            if (in_done) begin
              if (pend) err = 1;
              else if (!acc) begin
                if (!s_v || s_last) err = 1;
                else close_now = 1;
              end
            end
            if (pop) begin
              void'(q_dat.pop_front());
              void'(q_last.pop_front());
            end
            if (s_v && (acc || close_now)) begin
              if (!full) begin
                q_dat.push_back(s_dat);
                q_last.push_back(close_now);
                pushed = 1; plast = close_now;
                s_v = 0; s_last = 0; pend = 0;
              end else begin
                s_last = 1; pend = 1;
              end
            end
            if (acc) begin
              s_v = 1; s_dat = in_dat; s_last = in_done;
            end
            na = pushed && plast;
            ne = err;
          end
        end
        1: if (!in_abort) mst = 0;
        2: if (in_abort) begin mst = 3; nd = 1; end
        default: if (!in_abort) mst = 0;
      endcase
    end
    e_avail = na; e_err = ne; e_init = ni; e_done = nd;
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_done = 0; in_abort = 0; sw_abort = 0; in_dat = 0;
  endtask

  task automatic drain();
    idle_inputs();
    rd_ready = 1;
    repeat (DEPTH + 4) cycle();
    rd_ready = 0;
  endtask

  int a0, i0, d0, e0, ab_left;

  initial begin
    mst = 0; s_v = 0; s_last = 0; pend = 0; s_dat = 0;
    e_avail = 0; e_err = 0; e_init = 0; e_done = 0;
    n_avail = 0; n_err = 0; n_init = 0; n_done = 0;
    idle_inputs();
    rd_ready = 0;
    reset = 1;
    @(negedge aclk);
    check_eq("reset_in_ready", 32'(in_ready), 32'd0);
    check_eq("reset_word_count", 32'(word_count), 32'd0);
    repeat (2) cycle();
    reset = 0;
    cycle();

    // Three-word packet, done on its own cycle, consumer always ready.
    rd_ready = 1; pop_log.delete(); pop_last_log.delete(); a0 = n_avail;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_dat = 32'hA0 + i; cycle();
    end
    in_valid = 0; in_done = 1; cycle();
    in_done = 0;
    repeat (6) cycle();
    check_eq("t1_avail", 32'(n_avail - a0), 32'd1);
    check_eq("t1_npop", 32'(pop_log.size()), 32'd3);
    if (pop_log.size() == 3) begin
      check_eq("t1_w2", pop_log[2], 32'hA2);
      check_eq("t1_last1", 32'(pop_last_log[1]), 32'd0);
      check_eq("t1_last2", 32'(pop_last_log[2]), 32'd1);
    end

    // Done coincident with the final beat.
    rd_ready = 0;
    in_valid = 1; in_dat = 32'hB4; cycle();
    in_dat = 32'hB5; in_done = 1; cycle();
    idle_inputs();
    repeat (3) cycle();
    check_eq("t2_pkt", 32'(pkt_count), 32'd1);
    rd_ready = 1; cycle();
    check_eq("t2_dat", rd_dat, 32'hB5);
    check_eq("t2_last", 32'(rd_last), 32'd1);
    drain();

    // Overfill: FIFO full plus one staged word, then done parks in pending_last.
    for (int i = 0; i < DEPTH + 4; i++) begin
      in_valid = 1; in_dat = 32'hC00 + i; cycle();
    end
    check_eq("t3_ready_full", 32'(in_ready), 32'd0);
    check_eq("t3_words", 32'(word_count), DEPTH);
    in_valid = 0; in_done = 1; cycle();
    in_done = 0; a0 = n_avail; cycle();
    check_eq("t3_pend_ready", 32'(in_ready), 32'd0);
    rd_ready = 1; cycle();
    rd_ready = 0;
    repeat (3) cycle();
    check_eq("t3_avail", 32'(n_avail - a0), 32'd1);
    drain();
    check_eq("t3_drained", 32'(pkt_count), 32'd0);

    // Empty packet is an error; a following packet still completes.
    e0 = n_err; a0 = n_avail;
    in_done = 1; cycle();
    in_done = 0; repeat (2) cycle();
    check_eq("t4_err", 32'(n_err - e0), 32'd1);
    check_eq("t4_words", 32'(word_count), 32'd0);
    in_valid = 1; in_dat = 32'hD0; cycle();
    in_dat = 32'hD1; in_done = 1; cycle();
    idle_inputs(); repeat (3) cycle();
    check_eq("t4_avail", 32'(n_avail - a0), 32'd1);
    drain();

    // Remote abort flushes buffered words.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_dat = 32'hE0 + i; cycle();
    end
    in_valid = 0; cycle();
    check_eq("t5_words", 32'(word_count), 32'd5);
    i0 = n_init;
    in_abort = 1; repeat (4) cycle();
    check_eq("t5_flushed", 32'(word_count), 32'd0);
    check_eq("t5_init", 32'(n_init - i0), 32'd1);
    in_abort = 0; cycle();
    check_eq("t5_ready", 32'(in_ready), 32'd1);

    // Local abort handshake, then a simultaneous local/remote request.
    d0 = n_done;
    sw_abort = 1; cycle();
    sw_abort = 0;
    check_eq("t6_abort_out", 32'(abort_out), 32'd1);
    repeat (4) cycle();
    in_abort = 1; repeat (2) cycle();
    check_eq("t6_done", 32'(n_done - d0), 32'd1);
    check_eq("t6_clr_ready", 32'(in_ready), 32'd0);
    in_abort = 0; cycle();
    check_eq("t6_ready", 32'(in_ready), 32'd1);
    i0 = n_init; d0 = n_done;
    sw_abort = 1; in_abort = 1; cycle();
    sw_abort = 0; repeat (3) cycle();
    in_abort = 0; repeat (2) cycle();
    check_eq("t6_both_init", 32'(n_init - i0), 32'd1);
    check_eq("t6_both_done", 32'(n_done - d0), 32'd0);

    // Random traffic with aborts and one mid-stream reset.
    ab_left = 0;
    for (int i = 0; i < 4000; i++) begin
      in_valid = $urandom_range(0, 2) != 0;
      in_dat   = $urandom;
      in_done  = $urandom_range(0, 5) == 0;
      rd_ready = ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      sw_abort = $urandom_range(0, 199) == 0;
      in_abort = ab_left > 0;
      if (ab_left > 0) ab_left--;
      else if ($urandom_range(0, 249) == 0 || (mst == 2 && $urandom_range(0, 4) == 0))
        ab_left = $urandom_range(1, 6);
      reset = (i == 2000);
      cycle();
    end
    reset = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mbox_rx_buf.md
Name: mbox_rx_buf

Overview:
- Receive-side buffer that consumes the mailbox write stream produced by the mailbox APB block (mbox_w_dat/valid/ready/done/abort).
- Reframes the stream into a word FIFO with a per-word last flag, counts complete packets, and raises available/abort/error interrupts.
- Implements the receiver half of the abort handshake.
- Sits between the mailbox wire interface and the consuming core's local read port, in the aclk domain.

Parameters:
DEPTH, 16, FIFO depth in 32-bit words; power of two, minimum 4
CW, $clog2(DEPTH+1), width of occupancy and packet counters

Ports:
aclk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_dat  input  32  mailbox write data (from mbox_w_dat)
in_valid  input  1  data valid (from mbox_w_valid)
in_ready  output  1  data accepted (to mbox_w_ready)
in_done  input  1  one-cycle end-of-packet pulse (from mbox_w_done)
in_abort  input  1  sender abort level (from mbox_w_abort)
abort_out  output  1  receiver abort level (to mbox_r_abort)
sw_abort  input  1  one-cycle local abort request
rd_dat  output  32  head-of-FIFO word
rd_last  output  1  head word is final word of its packet
rd_valid  output  1  head word valid
rd_ready  input  1  consumer pops head
pkt_count  output  CW  complete packets held in FIFO
word_count  output  CW  words held in FIFO (excludes staging)
irq_available  output  1  one-cycle pulse when a packet completes into FIFO
irq_abort_init  output  1  one-cycle pulse on remote abort entry
irq_abort_done  output  1  one-cycle pulse when local abort is acknowledged
irq_error  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset: state NORMAL; FIFO, staging register and pending_last cleared; all outputs 0; in_ready held 0 while reset is high.
- Staging: accepted word (in_valid&in_ready) goes into the one-word stage, not the FIFO. If stage is already full, the old stage word is pushed to the FIFO with last=0 in the same cycle.
- Done handling:
  - in_done with stage full and FIFO not full: stage pushed with last=1 that cycle.
  - in_done with stage full and FIFO full: set pending_last; the push with last=1 happens on the first cycle the FIFO has room.
  - in_done coincident with an accepted beat: the incoming beat is the last word. It is written to stage and flagged, then committed with last=1 next cycle under the same rules.
- in_ready = state==NORMAL && !pending_last && (!stage_v || !full). Full is registered occupancy; a same-cycle pop does not raise in_ready.
- Read side:
  - rd_valid = state==NORMAL && !empty.
  - Pop on rd_valid&rd_ready.
  - rd_dat/rd_last are the head entry, zero when empty.
- Latency: first word visible on rd_* no earlier than the cycle after its last=1 or successor commit, i.e. at least 2 cycles after acceptance.
- Counters:
  - word_count: +1 on push, -1 on pop, unchanged on both.
  - pkt_count: +1 on push with last=1, -1 on pop of last=1, unchanged on both.
  - Neither counter wraps; reaching DEPTH is impossible beyond full.
- irq_available pulses exactly on the cycle a last=1 entry is pushed.
- Errors (irq_error pulse, no state change, no push):
  - in_done with stage empty and no coincident beat (empty packet).
  - in_done while pending_last is already set.
- State machine NORMAL / REMOTE_ABORT / LOCAL_ABORT / ABORT_CLR:
  - NORMAL → REMOTE_ABORT on in_abort=1. FIFO, stage, pending_last and counters flushed that cycle. abort_out=1 from the next cycle. irq_abort_init pulses.
  - REMOTE_ABORT → NORMAL when in_abort=0; abort_out drops the same cycle.
  - NORMAL → LOCAL_ABORT on sw_abort (in_abort=0). Flush as above; abort_out=1.
  - LOCAL_ABORT → ABORT_CLR on in_abort=1. abort_out drops; irq_abort_done pulses.
  - ABORT_CLR → NORMAL when in_abort=0.
  - Simultaneous sw_abort and in_abort in NORMAL: remote wins; sw_abort is ignored; only irq_abort_init pulses.
  - sw_abort outside NORMAL is ignored.
  - In all abort states: in_ready=0, rd_valid=0; in_done, in_valid and rd_ready are ignored.
- Reset mid-packet or mid-abort returns to NORMAL with everything empty.

Test Plan:
- Send 3 words 0xA0,0xA1,0xA2 then in_done, rd_ready=1 → rd sees A0/A1 last=0 and A2 last=1; irq_available pulses once; pkt_count goes 1→0.
- in_done coincident with final beat 0xB5 of a 2-word packet → 0xB5 is read with rd_last=1 and pkt_count=1 before any pop.
- rd_ready=0, DEPTH+1 words then in_done → in_ready low at 16 FIFO + 1 staged; pending_last set. One pop → last word pushed with last=1 next cycle; irq_available pulses.
- in_done with nothing staged → irq_error pulses; pkt_count and word_count unchanged. A subsequent normal packet still completes.
- 5 words buffered, in_abort raised → FIFO flushed (word_count=0); irq_abort_init pulses; abort_out=1 until in_abort falls, then NORMAL with in_ready=1.
- sw_abort pulse → abort_out=1. Raise in_abort 4 cycles later → abort_out=0 and irq_abort_done pulses; NORMAL only after in_abort=0. Repeat with sw_abort and in_abort in the same cycle → remote path only.
